// File: rtl/mult_pkg.sv
// +----------------------------------------------------------------------+
// | mult_pkg: func codes and sequencer states for the shift-add multiplier |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package mult_pkg;

  localparam logic [1:0] FUNC_HOLD   = 2'b00;
  localparam logic [1:0] FUNC_LOAD   = 2'b01;
  localparam logic [1:0] FUNC_SHIFTR = 2'b10;
  localparam logic [1:0] FUNC_RESET  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5,
    ABORT = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_add_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | shift_add_seq_ctrl: Moore sequencer issuing func codes to A/B/ACC      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_add_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       b_lsb,
  input  logic       b_zero,
  output logic [1:0] func_a,
  output logic [1:0] func_b,
  output logic [1:0] func_acc,
  output logic       add_en,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (start && !abort) state_d = CLR;
      CLR: begin
        cnt_d   = CNT_W'(WIDTH);
        state_d = TEST;
      end
      TEST: begin
        if (cnt_q == '0)                state_d = DONE;
        else if (EARLY_EXIT && b_zero)  state_d = DONE;
        else if (b_lsb)                 state_d = ADD;
        else                            state_d = SHIFT;
      end
      ADD:   state_d = SHIFT;
      SHIFT: begin
        // TEST exits before cnt reaches zero here, so this never wraps
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = TEST;
      end
      DONE:  state_d = IDLE;
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over every transition except out of IDLE and ABORT
    if (abort && state_q != IDLE && state_q != ABORT) state_d = ABORT;
  end

  always_comb begin
    func_a   = FUNC_HOLD;
    func_b   = FUNC_HOLD;
    func_acc = FUNC_HOLD;
    add_en   = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      CLR: begin
        func_a   = FUNC_LOAD;
        func_b   = FUNC_LOAD;
        func_acc = FUNC_RESET;
      end
      ADD: begin
        func_acc = FUNC_LOAD;
        add_en   = 1'b1;
      end
      SHIFT: func_b = FUNC_SHIFTR;
      DONE:  done   = 1'b1;
      ABORT: begin
        func_a   = FUNC_RESET;
        func_b   = FUNC_RESET;
        func_acc = FUNC_RESET;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_shift_add_seq_ctrl: sequence model + directed checks, both modes    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_shift_add_seq_ctrl;

  localparam int W = 4;

  // {func_a, func_b, func_acc, add_en, busy, done}
  localparam logic [8:0] V_IDLE  = 9'b00_00_00_0_0_0;
  localparam logic [8:0] V_CLR   = 9'b01_01_11_0_1_0;
  localparam logic [8:0] V_TEST  = 9'b00_00_00_0_1_0;
  localparam logic [8:0] V_ADD   = 9'b00_00_01_1_1_0;
  localparam logic [8:0] V_SHIFT = 9'b00_10_00_0_1_0;
  localparam logic [8:0] V_DONE  = 9'b00_00_00_0_1_1;
  localparam logic [8:0] V_ABORT = 9'b11_11_11_0_1_0;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic [3:0] b_in;

  logic [1:0][1:0] fa, fb, facc;
  logic [1:0]      add_en, busy, done, b_lsb, b_zero;
  logic [1:0][8:0] exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Output expected idx cycles after the accept edge (idx 0 = first cycle)
  function automatic logic [8:0] exp_at(logic [3:0] b, bit ee, int idx);
    int         k   = 1;
    int         cnt = W;
    logic [3:0] bb  = b;
    bit         fin = 1'b0;
    if (idx == 0) return V_CLR;
    for (int it = 0; it <= W && !fin; it++) begin
      if (idx == k) return V_TEST;
      k++;
      if (cnt == 0 || (ee && bb == 4'd0)) fin = 1'b1;
      else begin
        if (bb[0]) begin
          if (idx == k) return V_ADD;
          k++;
        end
        if (idx == k) return V_SHIFT;
        k++;
        bb  = bb >> 1;
        cnt = cnt - 1;
      end
    end
    if (idx == k) return V_DONE;
    return V_IDLE;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit EE = (g == 0);
    logic [3:0] b_reg = 4'd0;
    logic [3:0] b_lat = 4'd0;
    int         pos   = -1;
    bit         ab    = 1'b0;

    shift_add_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(EE)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .b_lsb    (b_lsb[g]),
      .b_zero   (b_zero[g]),
      .func_a   (fa[g]),
      .func_b   (fb[g]),
      .func_acc (facc[g]),
      .add_en   (add_en[g]),
      .busy     (busy[g]),
      .done     (done[g])
    );

    // B register of the datapath, not cleared by rst_n
    always @(posedge clk) begin
      case (fb[g])
        2'b01:   b_reg <= b_in;
        2'b10:   b_reg <= b_reg >> 1;
        2'b11:   b_reg <= 4'd0;
        default: b_reg <= b_reg;
      endcase
    end
    assign b_lsb[g]  = b_reg[0];
    assign b_zero[g] = (b_reg == 4'd0);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos <= -1;
        ab  <= 1'b0;
      end else if (ab) begin
        ab  <= 1'b0;
        pos <= -1;
      end else if (pos < 0) begin
        if (start && !abort) begin
          pos   <= 0;
          b_lat <= b_in;
        end
      end else if (abort) begin
        ab  <= 1'b1;
        pos <= -1;
      end else if (exp_at(b_lat, EE, pos + 1) == V_IDLE) begin
        pos <= -1;
      end else begin
        pos <= pos + 1;
      end
    end

    assign exp_v[g] = ab ? V_ABORT : (pos < 0 ? V_IDLE : exp_at(b_lat, EE, pos));
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if ({fa[g], fb[g], facc[g], add_en[g], busy[g], done[g]} !== exp_v[g]) begin
        n_fail++;
        $display("FAIL model[%0d] t=%0t outputs got %b expected %b", g, $time,
                 {fa[g], fb[g], facc[g], add_en[g], busy[g], done[g]}, exp_v[g]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] b, input int dc0, input int dc1,
                        input int ad0, input int ad1, input int sh1);
    int dc[2];
    int adc[2];
    int shc[2];
    dc  = '{0, 0};
    adc = '{0, 0};
    shc = '{0, 0};
    b_in = b;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (done[g] && dc[g] == 0) dc[g] = c;
        adc[g] += int'(add_en[g]);
        shc[g] += int'(fb[g] == 2'b10);
      end
    end
    chk($sformatf("done_cycle_ee b=%b", b), dc[0], dc0);
    chk($sformatf("done_cycle_full b=%b", b), dc[1], dc1);
    chk($sformatf("add_en_cycles_ee b=%b", b), adc[0], ad0);
    chk($sformatf("add_en_cycles_full b=%b", b), adc[1], ad1);
    chk($sformatf("shift_cycles_full b=%b", b), shc[1], sh1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; b_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_funcs", int'({fa[0], fb[0], facc[0]}), 0);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_done", int'(done[1]), 0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("idle_after_release", int'(busy), 0);

    run_op(4'b1011, 14, 14, 3, 3, 4);
    run_op(4'b0001, 6, 12, 1, 1, 4);
    run_op(4'b0000, 3, 11, 0, 0, 4);

    // abort in IDLE blocks a simultaneous start
    b_in = 4'b0101;
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("idle_abort_blocks_start", int'(busy), 0);

    // abort during the second ADD, start held high throughout
    b_in = 4'b1011;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    chk("second_add_before_abort", int'(add_en), 3);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_funcs", int'({fa[0], fb[0], facc[0]}), 6'b111111);
    chk("abort_no_done", int'(done), 0);
    @(negedge clk);
    chk("idle_after_abort", int'(busy), 0);
    @(negedge clk);
    chk("restart_clr", int'(fa[1]), 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);

    // asynchronous reset mid-SHIFT
    b_in = 4'b1011;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("in_shift", int'(fb[0]), 2);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_shift_fb", int'(fb[0]), 0);
    chk("reset_mid_shift_busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    run_op(4'b1011, 14, 14, 3, 3, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
